// File: rtl/spi_master.sv
// SPI bus master: full-duplex, LSB-first exchange of one DATA_WIDTH-bit word
// with one of NUM_SLAVES slaves; SCLK is clk gated by a negedge-registered enable.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            slaveSelect,
    input  logic [DATA_WIDTH-1:0] masterDataToSend,
    output logic [DATA_WIDTH-1:0] masterDataReceived,
    output logic                  SCLK,
    output logic [0:NUM_SLAVES-1] CS,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [1:0]            fsm_state
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    req_tog, ack_tog;
    logic                    pending, sel_ok;
    logic                    accept, drop;
    logic [0:NUM_SLAVES-1]   cs_q, cs_d;
    logic                    mosi_q, mosi_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   rx_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    sclk_en;

    // Request handshake: a start edge makes req_tog differ from ack_tog
    // (pending); accepting or dropping the request copies req_tog into ack_tog.
    // Repeated start edges before acceptance collapse into one request.
    always_ff @(posedge start or negedge reset) begin
        if (!reset) begin
            req_tog <= 1'b0;
        end else begin
            req_tog <= ~ack_tog;
        end
    end

    assign pending = req_tog ^ ack_tog;
    assign sel_ok  = ({1'b0, slaveSelect} < 3'(NUM_SLAVES));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    if (sel_ok) begin
                        accept  = 1'b1;
                        state_d = S_XFER;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            S_XFER: begin
                if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (pending && sel_ok) begin
                    accept  = 1'b1;
                    state_d = S_XFER;
                end else begin
                    drop    = pending;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the clk-rise registered outputs
    always_comb begin
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        tx_d    = tx_q;
        rdata_d = rdata_q;
        if (accept) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                cs_d[i] = (slaveSelect != i[1:0]);
            end
            mosi_d = masterDataToSend[0];
            tx_d   = masterDataToSend;
        end else if (state_q == S_XFER) begin
            if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                rdata_d = rx_q;
            end else if (bit_cnt != '0) begin
                // Pulse i (i >= 1) starts on this rise; present bit i
                mosi_d = tx_q[1];
                tx_d   = tx_q >> 1;
            end
        end else if (state_q == S_DONE) begin
            cs_d   = '1;
            mosi_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_tog <= 1'b0;
            cs_q    <= '1;
            mosi_q  <= 1'b0;
            tx_q    <= '0;
            rdata_q <= '0;
        end else begin
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            tx_q    <= tx_d;
            rdata_q <= rdata_d;
            if (accept || drop) begin
                ack_tog <= req_tog;
            end
        end
    end

    // Falling-edge side: SCLK enable, MISO sampling and bit counting.
    // The enable only changes while clk is low, so the gated SCLK cannot glitch.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            sclk_en <= 1'b0;
            bit_cnt <= '0;
            rx_q    <= '0;
        end else if (state_q != S_XFER) begin
            sclk_en <= 1'b0;
            bit_cnt <= '0;
        end else if (sclk_en) begin
            rx_q    <= {MISO, rx_q[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                sclk_en <= 1'b0;
            end
        end else if (bit_cnt == '0) begin
            sclk_en <= 1'b1;
        end
    end

    assign SCLK               = clk & sclk_en;
    assign CS                 = cs_q;
    assign MOSI               = mosi_q;
    assign masterDataReceived = rdata_q;
    assign fsm_state          = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural shift-register slave on the bus, random
// and directed exchanges, back-to-back, mid-transfer reset and invalid select.
module tb_spi_master;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] slaveSelect;
    logic [7:0] masterDataToSend;
    logic [7:0] masterDataReceived;
    logic       SCLK;
    logic [0:2] CS;
    logic       MOSI;
    logic       MISO;
    logic [1:0] fsm_state;

    int n_vec = 0;
    int n_err = 0;

    // Slave model and bus monitors
    logic [7:0] slave_reg;
    logic [0:2] exp_cs;
    int         sclk_pulses;
    int         cs_bad;
    int         cs_glitch;
    logic       watch_cs;
    logic [7:0] last_rx;

    spi_master #(.DATA_WIDTH(8), .NUM_SLAVES(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .slaveSelect        (slaveSelect),
        .masterDataToSend   (masterDataToSend),
        .masterDataReceived (masterDataReceived),
        .SCLK               (SCLK),
        .CS                 (CS),
        .MOSI               (MOSI),
        .MISO               (MISO),
        .fsm_state          (fsm_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave: shifts MOSI in on SCLK fall, presents its LSB on SCLK rise
    always @(negedge SCLK) slave_reg = {MOSI, slave_reg[7:1]};
    always @(posedge SCLK) begin
        MISO = slave_reg[0];
        sclk_pulses++;
        if (CS !== exp_cs) cs_bad++;
    end
    always @(negedge clk) begin
        if (watch_cs && CS !== exp_cs) cs_glitch++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:2] cs_for(input logic [1:0] sel);
        logic [0:2] v;
        v = 3'b111;
        if (sel < 2'd3) v[sel] = 1'b0;
        return v;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        #($urandom_range(1, 3));
        start = 1'b0;
    endtask

    // One transfer: accept on the first rise after start, completion nine rises later
    task automatic run_xfer(input logic [1:0] sel, input logic [7:0] tx, input logic [7:0] sv);
        slave_reg   = sv;
        MISO        = sv[0];
        sclk_pulses = 0;
        cs_bad      = 0;
        exp_cs      = cs_for(sel);
        @(posedge clk);
        #2;
        slaveSelect      = sel;
        masterDataToSend = tx;
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        check("rx_word", 32'(masterDataReceived), 32'(sv));
        check("slave_word", 32'(slave_reg), 32'(tx));
        check("sclk_pulses", 32'(sclk_pulses), 32'd8);
        check("cs_during_xfer", 32'(cs_bad), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("cs_idle", 32'(CS), 32'(3'b111));
        last_rx = sv;
    endtask

    initial begin : main
        logic [7:0] tx1, sv1, tx2, sv2;
        logic [1:0] sel;
        logic [7:0] sweep_tx [4];
        logic [7:0] sweep_sv [4];
        sweep_tx = '{8'hFF, 8'h0F, 8'h31, 8'h00};
        sweep_sv = '{8'h00, 8'hF0, 8'h1A, 8'hFF};

        reset = 1'b0;
        start = 1'b0;
        slaveSelect = 2'd0;
        masterDataToSend = 8'h00;
        MISO = 1'b0;
        slave_reg = 8'h00;
        exp_cs = 3'b111;
        sclk_pulses = 0;
        cs_bad = 0;
        cs_glitch = 0;
        watch_cs = 1'b0;
        last_rx = 8'h00;

        // Reset values, and a start pulse during reset must be ignored
        repeat (2) @(posedge clk);
        #2;
        slaveSelect = 2'd1;
        pulse_start();
        #1;
        check("reset_cs", 32'(CS), 32'(3'b111));
        check("reset_sclk", 32'(SCLK), 32'd0);
        check("reset_mosi", 32'(MOSI), 32'd0);
        check("reset_rx", 32'(masterDataReceived), 32'd0);
        check("reset_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("start_in_reset_pulses", 32'(sclk_pulses), 32'd0);
        check("start_in_reset_cs", 32'(CS), 32'(3'b111));

        // Basic transfer to slave 1
        run_xfer(2'd1, 8'h01, 8'h02);

        // Directed pattern sweep
        for (int i = 0; i < 4; i++) begin
            run_xfer(2'($urandom_range(0, 2)), sweep_tx[i], sweep_sv[i]);
        end

        // Random exchanges
        for (int i = 0; i < 8; i++) begin
            run_xfer(2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));
        end

        // Back-to-back: second start one cycle after the first completes
        sel = 2'($urandom_range(0, 2));
        tx1 = 8'($urandom);
        sv1 = 8'($urandom);
        tx2 = 8'($urandom);
        sv2 = sv1 ^ 8'($urandom_range(1, 255));
        slave_reg   = sv1;
        MISO        = sv1[0];
        sclk_pulses = 0;
        cs_glitch   = 0;
        exp_cs      = cs_for(sel);
        @(posedge clk);
        #2;
        slaveSelect      = sel;
        masterDataToSend = tx1;
        pulse_start();
        @(posedge clk);
        #1;
        watch_cs = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check("b2b_rx1", 32'(masterDataReceived), 32'(sv1));
        check("b2b_slave1", 32'(slave_reg), 32'(tx1));
        check("b2b_pulses1", 32'(sclk_pulses), 32'd8);
        #1;
        masterDataToSend = tx2;
        slave_reg = sv2;
        MISO      = sv2[0];
        pulse_start();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("b2b_first_pulse_no_gap", 32'(sclk_pulses), 32'd9);
        repeat (7) @(posedge clk);
        #1;
        check("b2b_rx_held", 32'(masterDataReceived), 32'(sv1));
        @(posedge clk);
        #1;
        check("b2b_rx2", 32'(masterDataReceived), 32'(sv2));
        check("b2b_slave2", 32'(slave_reg), 32'(tx2));
        check("b2b_pulses2", 32'(sclk_pulses), 32'd16);
        check("b2b_cs_no_glitch", 32'(cs_glitch), 32'd0);
        watch_cs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b2b_cs_idle", 32'(CS), 32'(3'b111));
        last_rx = sv2;

        // Invalid select: nothing on the bus, received word untouched
        sclk_pulses = 0;
        cs_glitch   = 0;
        exp_cs      = 3'b111;
        watch_cs    = 1'b1;
        @(posedge clk);
        #2;
        slaveSelect      = 2'd3;
        masterDataToSend = 8'($urandom);
        pulse_start();
        repeat (12) @(posedge clk);
        #1;
        watch_cs = 1'b0;
        check("badsel_pulses", 32'(sclk_pulses), 32'd0);
        check("badsel_cs", 32'(cs_glitch), 32'd0);
        check("badsel_rx", 32'(masterDataReceived), 32'(last_rx));
        run_xfer(2'd2, 8'hC3, 8'h5A);

        // Mid-transfer reset after three SCLK pulses
        slave_reg   = 8'h96;
        MISO        = 1'b0;
        sclk_pulses = 0;
        exp_cs      = cs_for(2'd0);
        @(posedge clk);
        #2;
        slaveSelect      = 2'd0;
        masterDataToSend = 8'hE7;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (sclk_pulses >= 3) break;
        end
        check("midreset_pulses_reached", 32'(sclk_pulses), 32'd3);
        reset = 1'b0;
        #1;
        check("midreset_cs", 32'(CS), 32'(3'b111));
        check("midreset_sclk", 32'(SCLK), 32'd0);
        check("midreset_mosi", 32'(MOSI), 32'd0);
        check("midreset_rx", 32'(masterDataReceived), 32'd0);
        #10;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        run_xfer(2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
